// File: rtl/fq_pkg.sv
// Shared constants and types for the frequency synthesiser and its measurer counterpart.
package fq_pkg;

  localparam int FQ_REF_FREQ = 1000000;
  localparam int FQ_WIDTH    = 32;

  typedef logic [FQ_WIDTH-1:0] freq_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } fq_state_e;

endpackage

// File: rtl/fq_synth_if.sv
// One-deep valid/ready configuration channel carrying a requested frequency in Hz.
interface fq_synth_if
  import fq_pkg::*;
#(
  parameter int WIDTH = FQ_WIDTH
);

  logic [WIDTH-1:0] cfg_freq;
  logic             cfg_valid;
  logic             cfg_ready;

  modport master (output cfg_freq, output cfg_valid, input  cfg_ready);
  modport slave  (input  cfg_freq, input  cfg_valid, output cfg_ready);

endinterface

// File: rtl/fq_synth_accum.sv
// Bresenham accumulator: adds 2*f_cur per step and toggles the wave each time REF_FREQ is crossed.
module fq_accum
  import fq_pkg::*;
#(
  parameter int REF_FREQ = FQ_REF_FREQ,
  parameter int WIDTH    = FQ_WIDTH
) (
  input  logic             ref_clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] f_cur,
  input  logic             step,
  input  logic             clear,
  output logic             wave,
  output logic             fall
);

  localparam logic [WIDTH+1:0] REF_W = (WIDTH+2)'(REF_FREQ);

  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] sum;
  logic             toggle;

  // f_cur never exceeds REF_FREQ/2, so one subtraction always brings sum back in range
  always_comb begin
    sum    = acc + {1'b0, f_cur, 1'b0};
    toggle = step && (sum >= REF_W);
    fall   = toggle && wave;
  end

  always_ff @(posedge ref_clk or negedge nReset) begin
    if (!nReset) begin
      acc  <= '0;
      wave <= 1'b0;
    end else if (clear) begin
      acc  <= '0;
      wave <= 1'b0;
    end else if (step) begin
      acc <= toggle ? (sum - REF_W) : sum;
      if (toggle) wave <= ~wave;
    end
  end

endmodule

// File: rtl/fq_synth.sv
// Programmable square-wave generator; new frequencies take effect only on a falling edge of out_freq.
//   state    | meaning
//   IDLE     | output held low, waiting for enable and a non-zero frequency
//   RUN      | accumulating; pending config loaded at each fall
//   STOPPING | enable dropped while high; finish the high phase then idle
module fq_synth
  import fq_pkg::*;
#(
  parameter int REF_FREQ = FQ_REF_FREQ,
  parameter int WIDTH    = FQ_WIDTH
) (
  input  logic       ref_clk,
  input  logic       nReset,
  input  logic       enable,
  fq_synth_if.slave  cfg,
  output logic       out_freq,
  output logic       active,
  output logic       period_done,
  output logic       clamped
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_STOPPING = STOPPING;

  localparam logic [WIDTH-1:0] F_MAX = WIDTH'(REF_FREQ / 2);

  logic [1:0]       state;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] f_cur;
  logic             pend_valid;
  logic             accept;
  logic             step;
  logic             clear;
  logic             fall;

  assign cfg.cfg_ready = ~pend_valid;
  assign accept        = cfg.cfg_valid && ~pend_valid;
  assign active        = (state != ST_IDLE);

  always_comb begin
    step  = 1'b0;
    clear = 1'b0;
    case (state)
      ST_IDLE:     clear = 1'b1;
      // enable low with the output already low stops without another step
      ST_RUN: begin
        step  = enable || out_freq;
        clear = fall && pend_valid;
      end
      ST_STOPPING: step = 1'b1;
      default:     clear = 1'b1;
    endcase
  end

  fq_accum #(
    .REF_FREQ (REF_FREQ),
    .WIDTH    (WIDTH)
  ) u_accum (
    .ref_clk (ref_clk),
    .nReset  (nReset),
    .f_cur   (f_cur),
    .step    (step),
    .clear   (clear),
    .wave    (out_freq),
    .fall    (fall)
  );

  // accept needs an empty slot and a drain needs a full one, so they never collide
  always_ff @(posedge ref_clk or negedge nReset) begin
    if (!nReset) begin
      state       <= ST_IDLE;
      pend        <= '0;
      pend_valid  <= 1'b0;
      f_cur       <= '0;
      clamped     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      period_done <= fall;
      if (accept) begin
        pend       <= (cfg.cfg_freq > F_MAX) ? F_MAX : cfg.cfg_freq;
        pend_valid <= 1'b1;
        clamped    <= (cfg.cfg_freq > F_MAX);
      end
      case (state)
        ST_IDLE: begin
          if (enable && pend_valid) begin
            f_cur      <= pend;
            pend_valid <= 1'b0;
            state      <= (pend != '0) ? ST_RUN : ST_IDLE;
          end else if (enable && (f_cur != '0)) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fall) begin
            if (pend_valid) begin
              f_cur      <= pend;
              pend_valid <= 1'b0;
              state      <= (pend != '0) ? ST_RUN : ST_IDLE;
            end else if (!enable) begin
              state <= ST_IDLE;
            end
          end else if (!enable) begin
            state <= out_freq ? ST_STOPPING : ST_IDLE;
          end
        end
        ST_STOPPING: begin
          if (fall)        state <= ST_IDLE;
          else if (enable) state <= ST_RUN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fq_synth.sv
// Directed bench for fq_synth at REF_FREQ=100 with hand-computed waveforms.
module tb_fq_synth;

  logic ref_clk = 1'b0;
  logic nReset  = 1'b0;
  logic enable  = 1'b0;
  logic out_freq, active, period_done, clamped;

  int n_checks = 0;
  int n_errors = 0;

  fq_synth_if #(.WIDTH(32)) cfg_bus ();

  fq_synth #(.REF_FREQ(100), .WIDTH(32)) dut (
    .ref_clk     (ref_clk),
    .nReset      (nReset),
    .enable      (enable),
    .cfg         (cfg_bus.slave),
    .out_freq    (out_freq),
    .active      (active),
    .period_done (period_done),
    .clamped     (clamped)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic send_cfg(input logic [31:0] f);
    int n = 0;
    while (!cfg_bus.cfg_ready && n < 50) begin
      @(negedge ref_clk);
      n++;
    end
    cfg_bus.cfg_freq  = f;
    cfg_bus.cfg_valid = 1'b1;
    @(negedge ref_clk);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_pd(input string tag, input int bound);
    int n = 0;
    do begin
      @(negedge ref_clk);
      n++;
    end while (!period_done && n < bound);
    check(tag, period_done, 1);
  endtask

  task automatic wait_high(input string tag, input int bound);
    int n = 0;
    while (!out_freq && n < bound) begin
      @(negedge ref_clk);
      n++;
    end
    check(tag, out_freq, 1);
  endtask

  task automatic collect(input int n, output logic [15:0] ov, output logic [15:0] pv);
    ov = '0;
    pv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge ref_clk);
      ov = {ov[14:0], out_freq};
      pv = {pv[14:0], period_done};
    end
  endtask

  task automatic measure(input int n, output int tg, output int pc);
    logic prev;
    prev = out_freq;
    tg = 0;
    pc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge ref_clk);
      if (out_freq != prev) tg++;
      if (period_done) pc++;
      prev = out_freq;
    end
  endtask

  initial begin
    logic [15:0] ov, pv;
    int tg, pc, n;

    cfg_bus.cfg_freq  = '0;
    cfg_bus.cfg_valid = 1'b0;

    repeat (2) @(negedge ref_clk);
    check("rst_out", out_freq, 0);
    check("rst_active", active, 0);
    check("rst_pd", period_done, 0);
    check("rst_clamped", clamped, 0);
    check("rst_ready", cfg_bus.cfg_ready, 1);
    nReset = 1'b1;
    enable = 1'b1;
    @(negedge ref_clk);
    check("idle_no_cfg", active, 0);

    // 25 Hz: rise 2 edges after load, period 4
    send_cfg(32'd25);
    check("ready_pending", cfg_bus.cfg_ready, 0);
    @(negedge ref_clk);
    check("ready_drained", cfg_bus.cfg_ready, 1);
    check("load_active", active, 1);
    check("load_out", out_freq, 0);
    collect(8, ov, pv);
    check("f25_wave", ov[7:0], 8'b01100110);
    check("f25_pd", pv[7:0], 8'b00010001);

    // 30 Hz over 100 cycles from a fresh load
    send_cfg(32'd30);
    wait_pd("f30_load", 50);
    measure(100, tg, pc);
    check("f30_toggles", tg, 60);
    check("f30_pulses", pc, 30);
    check("f30_clamped", clamped, 0);

    send_cfg(32'd50);
    wait_pd("f50_load", 50);
    collect(8, ov, pv);
    check("f50_wave", ov[7:0], 8'b10101010);
    check("f50_pd", pv[7:0], 8'b01010101);

    send_cfg(32'd80);
    check("f80_clamped", clamped, 1);
    wait_pd("f80_load", 50);
    collect(8, ov, pv);
    check("f80_wave", ov[7:0], 8'b10101010);
    check("f80_pd", pv[7:0], 8'b01010101);

    send_cfg(32'd10);
    check("f10_unclamped", clamped, 0);
    wait_pd("f10_load", 50);

    // 25 Hz, then 10 accepted mid high phase and held valid while pending
    send_cfg(32'd25);
    wait_pd("sw_load25", 50);
    @(negedge ref_clk);
    check("sw_n1_out", out_freq, 0);
    @(negedge ref_clk);
    check("sw_n2_out", out_freq, 1);
    cfg_bus.cfg_freq  = 32'd10;
    cfg_bus.cfg_valid = 1'b1;
    @(negedge ref_clk);
    check("sw_ready_busy", cfg_bus.cfg_ready, 0);
    check("sw_n3_out", out_freq, 1);
    check("sw_n3_pd", period_done, 0);
    @(negedge ref_clk);
    check("sw_fall_pd", period_done, 1);
    check("sw_fall_out", out_freq, 0);
    cfg_bus.cfg_valid = 1'b0;
    collect(10, ov, pv);
    check("sw_f10_wave", ov[9:0], 10'b0000111110);
    check("sw_f10_pd", pv[9:0], 10'b0000000001);

    // enable dropped while high: finish high phase in STOPPING
    wait_high("stop_high", 50);
    enable = 1'b0;
    n = 0;
    do begin
      @(negedge ref_clk);
      n++;
      if (n == 1) check("stop_active", active, 1);
    end while (!period_done && n < 50);
    check("stop_cycles", n, 5);
    check("stop_pd", period_done, 1);
    check("stop_idle", active, 0);
    check("stop_out", out_freq, 0);
    @(negedge ref_clk);
    check("stop_after_pd", period_done, 0);

    // enable dropped while low: straight to IDLE
    enable = 1'b1;
    @(negedge ref_clk);
    check("relaunch_active", active, 1);
    check("relaunch_out", out_freq, 0);
    enable = 1'b0;
    @(negedge ref_clk);
    check("low_stop_active", active, 0);
    check("low_stop_out", out_freq, 0);

    // zero frequency while running ends at the next fall
    enable = 1'b1;
    send_cfg(32'd0);
    wait_pd("zero_fall", 50);
    check("zero_idle", active, 0);
    check("zero_out", out_freq, 0);
    repeat (3) @(negedge ref_clk);
    check("zero_stays_idle", active, 0);

    // async reset mid-RUN with a pending value
    send_cfg(32'd30);
    wait_high("rst_run_high", 50);
    send_cfg(32'd80);
    check("rst_pre_clamped", clamped, 1);
    check("rst_pre_ready", cfg_bus.cfg_ready, 0);
    #2 nReset = 1'b0;
    #1;
    check("arst_out", out_freq, 0);
    check("arst_active", active, 0);
    check("arst_pd", period_done, 0);
    check("arst_clamped", clamped, 0);
    check("arst_ready", cfg_bus.cfg_ready, 1);
    @(negedge ref_clk);
    nReset = 1'b1;
    repeat (3) @(negedge ref_clk);
    check("post_rst_idle", active, 0);
    check("post_rst_out", out_freq, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fq_synth.md
Name: fq_synth

Overview:
- Programmable square-wave generator clocked from the reference clock. Converts a requested frequency in Hz into a 50%-average-duty output.
- Counterpart of the frequency measurer: the synth output can be looped into the measurer input for self-test.
- Uses a Bresenham-style fractional accumulator, so there is no division and the long-run frequency is exact.
- Configuration arrives over a one-deep valid/ready interface. New values are applied only at period boundaries, so the output never glitches.

Parameters:
- REF_FREQ, 1000000: reference clock frequency in Hz.
- WIDTH, 32: width of frequency words.

Ports:
- ref_clk  input  1  reference clock; all logic on posedge.
- nReset  input  1  reset, asynchronous, active-low.
- enable  input  1  run request; low drains to idle at a period boundary.
- cfg_freq  input  WIDTH  requested frequency in Hz.
- cfg_valid  input  1  cfg_freq valid.
- cfg_ready  output  1  pending slot empty; accept when cfg_valid && cfg_ready.
- out_freq  output  1  generated square wave (registered).
- active  output  1  high in RUN and STOPPING.
- period_done  output  1  one-cycle pulse on each high-to-low toggle of out_freq.
- clamped  output  1  last accepted cfg_freq exceeded REF_FREQ/2. Sticky until the next acceptance.

Behaviour:
- Reset values:
  - out_freq=0, active=0, period_done=0, clamped=0, cfg_ready=1.
  - acc=0, f_cur=0, pend_valid=0, state=IDLE.
- Acceptance:
  - On an edge with cfg_valid && cfg_ready: pend <= min(cfg_freq, REF_FREQ/2) and pend_valid <= 1.
  - clamped <= (cfg_freq > REF_FREQ/2).
  - cfg_ready is registered as !pend_valid. No accept and drain can occur in the same cycle.
- Accumulator:
  - Width WIDTH+2, unsigned.
  - Each RUN/STOPPING edge: sum = acc + 2*f_cur.
  - If sum >= REF_FREQ: acc <= sum - REF_FREQ and out_freq toggles. Otherwise acc <= sum.
  - The clamp guarantees at most one subtraction. The result is 2*f_cur toggles per REF_FREQ cycles, i.e. exactly f_cur Hz.
- State IDLE:
  - out_freq=0, acc held at 0.
  - If enable && pend_valid: f_cur <= pend, pend_valid <= 0, acc <= 0.
    - Go to RUN if pend != 0; otherwise stay in IDLE.
    - No accumulation on this load edge.
  - Else if enable && !pend_valid && f_cur != 0: go to RUN with acc <= 0.
- State RUN:
  - Accumulate every edge.
  - On an edge where out_freq toggles 1->0, period_done=1 and the following apply:
    - if pend_valid: f_cur <= pend, pend_valid <= 0, acc <= 0. A value of 0 goes to IDLE.
    - if !enable (and no pending value): go to IDLE.
  - If enable drops while out_freq=0: go to IDLE next edge without toggling.
  - If enable drops while out_freq=1: go to STOPPING.
- State STOPPING:
  - Accumulate until the 1->0 toggle, then period_done=1 and go to IDLE.
  - A pending value stays pending.
  - Re-asserting enable in STOPPING returns to RUN on the next edge with acc kept.
- First rising edge of out_freq after load: ceil(REF_FREQ/(2*f)) edges after the load edge.
- f = REF_FREQ/2 toggles every cycle. An output of 0 Hz is expressed as IDLE.
- Mid-operation nReset: immediate return to reset values. The pending value is lost.

Decomposition:
- Package fq_pkg holds:
  - REF_FREQ constant, shared with the measurer and replacing the file-local define.
  - freq_t typedef logic [WIDTH-1:0].
  - State enum {IDLE, RUN, STOPPING}.
- Sub-module fq_accum: the accumulator, compare/subtract and toggle datapath.
  - Inputs: f_cur, step enable, clear.
  - Outputs: toggle, fall strobe.
- The FSM and configuration handshake stay in fq_synth.

Test Plan (REF_FREQ=100):
- Reset; cfg_freq=25 accepted, enable=1 -> out_freq rises 2 edges after the load edge and toggles every 2 cycles (period 4); period_done pulses every 4 cycles; cfg_ready back to 1 one cycle after the drain.
- cfg_freq=30 -> exactly 60 toggles and 30 period_done pulses per 100 cycles; cfg_freq=50 -> toggles every cycle.
- cfg_freq=80 -> clamped=1 and behaviour identical to 50. A following accepted cfg_freq=10 -> clamped=0.
- Running at 25, accept 10 mid high-phase -> 25 Hz continues until the next 1->0 toggle, then period 10 cycles with no runt pulse; cfg_valid held meanwhile sees cfg_ready=0.
- enable dropped while out_freq=1 -> STOPPING, one final fall with period_done, then IDLE with active=0 and out_freq=0; enable dropped while out_freq=0 -> IDLE next edge.
- Accept cfg_freq=0 while running -> IDLE at the next fall. nReset asserted mid-RUN -> all outputs 0 immediately, cfg_ready=1.
